// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer
// Shares one combinational 4-bit ALU between NUM_REQ requesters. A
// round-robin arbiter picks one valid requester per IDLE cycle. Its operands
// are registered onto the ALU inputs and held for ALU_LAT cycles. The result
// is then captured and offered on a single response channel, tagged with the
// requester index. Reset is asserted asynchronously. Its release is expected
// to be synchronous to clk.

module alu_rr_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3*NUM_REQ-1:0] req_code,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [2:0]           alu_code,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  input  logic [7:0]           alu_result,
  input  logic                 alu_flag_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result,
  output logic                 rsp_flag_c,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [3:0]      cnt;
  logic [ID_W-1:0] last;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            handshake;
  logic            exec_done;
  logic            rsp_accept;
  logic [2:0]      sel_code;
  logic [3:0]      sel_a;
  logic [3:0]      sel_b;

  // Round-robin search. Candidates are visited in the order last+1, last+2,
  // and so on, wrapping modulo NUM_REQ. The first valid one wins. The MSB of
  // the return value flags that a candidate was found.
  function automatic logic [ID_W:0] pick_grant(
    input logic [NUM_REQ-1:0] valid,
    input logic [ID_W-1:0]    last_idx
  );
    logic [ID_W:0]   res;
    logic [ID_W-1:0] cand_idx;
    int              cand;
    res = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_idx) + k) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!res[ID_W] && valid[cand_idx]) begin
        res = {1'b1, cand_idx};
      end
    end
    return res;
  endfunction

  // Arbitration result for the current cycle. It only matters in IDLE.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    {grant_found, grant_idx} = pick_grant(req_valid, last);
  end

  // Issue the one-hot ready, in IDLE only. While reset is asserted the ready
  // is forced low, because IDLE would otherwise grant combinationally.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  // Mux the operands of the granted requester.
  always_comb begin
    sel_code = req_code[3*int'(grant_idx) +: 3];
    sel_a    = req_a[4*int'(grant_idx) +: 4];
    sel_b    = req_b[4*int'(grant_idx) +: 4];
  end

  // Qualified events that drive the state machine.
  always_comb begin
    handshake  = (state == S_IDLE) && grant_found;
    exec_done  = (state == S_EXEC) && (cnt == 4'd0);
    rsp_accept = (state == S_RESP) && rsp_ready;
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE. The unused encoding
  // falls back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (handshake)  state_next = S_EXEC;
      S_EXEC: if (exec_done)  state_next = S_RESP;
      S_RESP: if (rsp_accept) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latency counter. It is loaded on the handshake and counts down in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (handshake) begin
      cnt <= CNT_LOAD;
    end else if ((state == S_EXEC) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Round-robin pointer. After reset it points at the last requester, so
  // requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= ID_W'(NUM_REQ - 1);
    end else if (handshake) begin
      last <= grant_idx;
    end
  end

  // ALU drive registers. They change only on a handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_code <= 3'd0;
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
    end else if (handshake) begin
      alu_code <= sel_code;
      alu_a    <= sel_a;
      alu_b    <= sel_b;
    end
  end

  // Response owner id. It is captured at grant time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id <= '0;
    end else if (handshake) begin
      rsp_id <= grant_idx;
    end
  end

  // Capture the ALU result at the end of the hold window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= 8'd0;
      rsp_flag_c <= 1'b0;
    end else if (exec_done) begin
      rsp_result <= alu_result;
      rsp_flag_c <= alu_flag_c;
    end
  end

  // Status outputs are decoded from the registered state.
  always_comb begin
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE);
  end

endmodule
